// File: rtl/machine_timer.sv
// machine_timer: memory-mapped RISC-V machine timer (mtime / mtimecmp) with a
// prescaler, a timer interrupt compare, an atomic-read shadow for mtime[63:32]
// and a synchroniser that brings the asynchronous external interrupt into the
// clk domain. Software reaches it over a request/ack port with one cycle of latency.
module machine_timer #(
   parameter int PRESCALE    = 1,   // clk cycles per mtime increment (>=1)
   parameter int SYNC_STAGES = 2    // flops in the ext interrupt synchroniser (>=2)
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req,
   input  logic        we,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   input  logic        ext_irq_in,
   output logic        ext_intr,
   output logic        timer_intr
);

   // Prescale counter width; one bit is enough when every cycle is a tick.
   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   // Register indices, taken from addr[4:2].
   localparam logic [2:0] IDX_MTIME_LO    = 3'd0;
   localparam logic [2:0] IDX_MTIME_HI    = 3'd1;
   localparam logic [2:0] IDX_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] IDX_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] IDX_CTRL        = 3'd4;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [63:0]     mtime_reg;
   logic [63:0]     mtime_next;
   logic [63:0]     mtimecmp_reg;
   logic [63:0]     mtimecmp_next;
   logic            enable_reg;
   logic            enable_next;
   logic [PS_W-1:0] ps_cnt_reg;
   logic [PS_W-1:0] ps_cnt_next;
   logic [31:0]     shadow_reg;
   logic [31:0]     shadow_next;
   logic [31:0]     rdata_reg;
   logic [31:0]     rdata_next;
   logic            ack_reg;
   logic            timer_intr_reg;
   logic            timer_intr_next;
   logic [SYNC_STAGES-1:0] sync_reg;

   // ------------------------------------------------------------------
   // Access decode
   // ------------------------------------------------------------------
   logic [2:0] reg_idx;
   logic       wr_en;
   logic       rd_en;
   logic       wr_mtime_lo;
   logic       wr_mtime_hi;
   logic       wr_cmp_lo;
   logic       wr_cmp_hi;
   logic       wr_ctrl;
   logic       rd_mtime_lo;
   logic       tick;
   logic [31:0] rd_value;

   // Byte-offset bits are ignored by the register map.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr[1:0];

   assign reg_idx     = addr[4:2];
   assign wr_en       = req & we;
   assign rd_en       = req & ~we;
   assign wr_mtime_lo = wr_en && (reg_idx == IDX_MTIME_LO);
   assign wr_mtime_hi = wr_en && (reg_idx == IDX_MTIME_HI);
   assign wr_cmp_lo   = wr_en && (reg_idx == IDX_MTIMECMP_LO);
   assign wr_cmp_hi   = wr_en && (reg_idx == IDX_MTIMECMP_HI);
   assign wr_ctrl     = wr_en && (reg_idx == IDX_CTRL);
   assign rd_mtime_lo = rd_en && (reg_idx == IDX_MTIME_LO);

   // A tick is the terminal count of the prescaler while counting is enabled.
   assign tick = enable_reg && (ps_cnt_reg == PS_LAST);

   // ------------------------------------------------------------------
   // Prescaler: wraps on terminal count, holds its value while disabled.
   // ------------------------------------------------------------------
   always_comb begin
      ps_cnt_next = ps_cnt_reg;
      if (enable_reg) begin
         if (ps_cnt_reg == PS_LAST)
            ps_cnt_next = '0;
         else
            ps_cnt_next = ps_cnt_reg + 1'b1;
      end
   end

   // Prescale counter register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         ps_cnt_reg <= '0;
      else
         ps_cnt_reg <= ps_cnt_next;
   end

   // ------------------------------------------------------------------
   // mtime: a software write to either half wins over a coincident tick,
   // and that tick is dropped rather than applied to the written value.
   // ------------------------------------------------------------------
   always_comb begin
      mtime_next = mtime_reg;
      if (wr_mtime_lo)
         mtime_next = {mtime_reg[63:32], wdata};
      else if (wr_mtime_hi)
         mtime_next = {wdata, mtime_reg[31:0]};
      else if (tick)
         mtime_next = mtime_reg + 64'd1;
   end

   // mtime register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         mtime_reg <= '0;
      else
         mtime_reg <= mtime_next;
   end

   // ------------------------------------------------------------------
   // mtimecmp and control: plain software-written registers.
   // ------------------------------------------------------------------
   always_comb begin
      mtimecmp_next = mtimecmp_reg;
      enable_next   = enable_reg;
      if (wr_cmp_lo)
         mtimecmp_next = {mtimecmp_reg[63:32], wdata};
      if (wr_cmp_hi)
         mtimecmp_next = {wdata, mtimecmp_reg[31:0]};
      if (wr_ctrl)
         enable_next = wdata[0];
   end

   // mtimecmp resets to all-ones so no interrupt fires before software sets it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mtimecmp_reg <= '1;
         enable_reg   <= 1'b0;
      end else begin
         mtimecmp_reg <= mtimecmp_next;
         enable_reg   <= enable_next;
      end
   end

   // ------------------------------------------------------------------
   // Read path. Reading MTIME_LO snapshots the upper half so a following
   // MTIME_HI read returns a value consistent with the low word.
   // ------------------------------------------------------------------
   always_comb begin
      rd_value = '0;
      case (reg_idx)
         IDX_MTIME_LO:    rd_value = mtime_reg[31:0];
         IDX_MTIME_HI:    rd_value = shadow_reg;
         IDX_MTIMECMP_LO: rd_value = mtimecmp_reg[31:0];
         IDX_MTIMECMP_HI: rd_value = mtimecmp_reg[63:32];
         IDX_CTRL:        rd_value = {31'd0, enable_reg};
         default:         rd_value = '0;
      endcase
   end

   // Next read data and shadow capture; rdata stays zero unless a read is acked.
   always_comb begin
      rdata_next  = '0;
      shadow_next = shadow_reg;
      if (rd_en)
         rdata_next = rd_value;
      if (rd_mtime_lo)
         shadow_next = mtime_reg[63:32];
   end

   // Bus response registers: every request is acked exactly one cycle later.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdata_reg  <= '0;
         ack_reg    <= 1'b0;
         shadow_reg <= '0;
      end else begin
         rdata_reg  <= rdata_next;
         ack_reg    <= req;
         shadow_reg <= shadow_next;
      end
   end

   assign rdata = rdata_reg;
   assign ack   = ack_reg;

   // ------------------------------------------------------------------
   // Timer interrupt: registered level compare, unsigned 64-bit.
   // ------------------------------------------------------------------
   always_comb begin
      timer_intr_next = enable_reg && (mtime_reg >= mtimecmp_reg);
   end

   // Timer interrupt register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         timer_intr_reg <= 1'b0;
      else
         timer_intr_reg <= timer_intr_next;
   end

   assign timer_intr = timer_intr_reg;

   // ------------------------------------------------------------------
   // External interrupt synchroniser: a plain flop chain, level through.
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         logic stage_in;
         if (gi == 0) begin : g_first
            assign stage_in = ext_irq_in;
         end else begin : g_rest
            assign stage_in = sync_reg[gi-1];
         end

         // One synchroniser stage.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)
               sync_reg[gi] <= 1'b0;
            else
               sync_reg[gi] <= stage_in;
         end
      end
   endgenerate

   assign ext_intr = sync_reg[SYNC_STAGES-1];

endmodule

// File: tb/tb_machine_timer.sv
// Bench for machine_timer: two instances (PRESCALE=1 and PRESCALE=4) on a
// shared bus/reset, a table of register vectors plus directed timing sequences.
module tb_machine_timer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic        ext_irq_in;
   logic        req1, req4;
   logic [31:0] rdata1, rdata4;
   logic        ack1, ack4;
   logic        ext1, ext4;
   logic        tint1, tint4;

   machine_timer #(.PRESCALE(1), .SYNC_STAGES(2)) u_dut1 (
      .clk(clk), .rstn(rstn), .req(req1), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata1), .ack(ack1), .ext_irq_in(ext_irq_in), .ext_intr(ext1),
      .timer_intr(tint1)
   );

   machine_timer #(.PRESCALE(4), .SYNC_STAGES(2)) u_dut4 (
      .clk(clk), .rstn(rstn), .req(req4), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata4), .ack(ack4), .ext_irq_in(ext_irq_in), .ext_intr(ext4),
      .timer_intr(tint4)
   );

   localparam logic [4:0] A_MT_LO  = 5'h00;
   localparam logic [4:0] A_MT_HI  = 5'h04;
   localparam logic [4:0] A_CMP_LO = 5'h08;
   localparam logic [4:0] A_CMP_HI = 5'h0C;
   localparam logic [4:0] A_CTRL   = 5'h10;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // One bus access; starts just after a negedge, returns at the next negedge.
   task automatic access(input int sel, input logic w, input logic [4:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic ak);
      we = w; addr = a; wdata = d;
      if (sel == 1) req1 = 1'b1; else req4 = 1'b1;
      @(negedge clk);
      req1 = 1'b0; req4 = 1'b0; we = 1'b0;
      if (sel == 1) begin rd = rdata1; ak = ack1; end
      else          begin rd = rdata4; ak = ack4; end
   endtask

   task automatic wr(input int sel, input logic [4:0] a, input logic [31:0] d, input string name);
      logic [31:0] rd;
      logic ak;
      access(sel, 1'b1, a, d, rd, ak);
      check({name, " ack"}, {31'd0, ak}, 32'd1);
   endtask

   task automatic rd_chk(input int sel, input logic [4:0] a, input logic [31:0] exp, input string name);
      logic [31:0] rd;
      logic ak;
      access(sel, 1'b0, a, 32'd0, rd, ak);
      check({name, " ack"}, {31'd0, ak}, 32'd1);
      check(name, rd, exp);
   endtask

   typedef struct {
      logic        w;
      logic [4:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[16];

   initial begin
      int cnt;
      int first;
      logic [31:0] rd;
      logic ak;

      // Register vectors, applied to the PRESCALE=4 instance while disabled.
      vecs[0]  = '{1'b1, A_CMP_LO, 32'h1234_5678, 32'h0,         "tbl wr cmp_lo"};
      vecs[1]  = '{1'b0, A_CMP_LO, 32'h0,         32'h1234_5678, "tbl rd cmp_lo"};
      vecs[2]  = '{1'b0, A_CMP_HI, 32'h0,         32'hFFFF_FFFF, "tbl cmp_hi untouched"};
      vecs[3]  = '{1'b1, A_CMP_HI, 32'hABCD_0001, 32'h0,         "tbl wr cmp_hi"};
      vecs[4]  = '{1'b0, A_CMP_HI, 32'h0,         32'hABCD_0001, "tbl rd cmp_hi"};
      vecs[5]  = '{1'b0, 5'h09,    32'h0,         32'h1234_5678, "tbl addr[1:0] ignored"};
      vecs[6]  = '{1'b1, A_MT_LO,  32'hDEAD_BEEF, 32'h0,         "tbl wr mtime_lo"};
      vecs[7]  = '{1'b1, A_MT_HI,  32'h0000_0042, 32'h0,         "tbl wr mtime_hi"};
      vecs[8]  = '{1'b0, A_MT_HI,  32'h0,         32'h0,         "tbl hi before lo = shadow 0"};
      vecs[9]  = '{1'b0, A_MT_LO,  32'h0,         32'hDEAD_BEEF, "tbl rd mtime_lo"};
      vecs[10] = '{1'b0, A_MT_HI,  32'h0,         32'h0000_0042, "tbl rd mtime_hi"};
      vecs[11] = '{1'b0, A_CTRL,   32'h0,         32'h0,         "tbl rd ctrl"};
      vecs[12] = '{1'b1, 5'h14,    32'hFFFF_FFFF, 32'h0,         "tbl wr unmapped"};
      vecs[13] = '{1'b0, 5'h14,    32'h0,         32'h0,         "tbl rd unmapped 5"};
      vecs[14] = '{1'b0, 5'h1C,    32'h0,         32'h0,         "tbl rd unmapped 7"};
      vecs[15] = '{1'b0, A_CTRL,   32'h0,         32'h0,         "tbl ctrl after unmapped wr"};

      rstn = 1'b0; req1 = 1'b0; req4 = 1'b0; we = 1'b0;
      addr = '0; wdata = '0; ext_irq_in = 1'b0;

      // Reset values.
      repeat (3) @(negedge clk);
      check("reset rdata1", rdata1, 32'h0);
      check("reset ack1", {31'd0, ack1}, 32'h0);
      check("reset timer_intr1", {31'd0, tint1}, 32'h0);
      check("reset ext_intr1", {31'd0, ext1}, 32'h0);
      check("reset ack4", {31'd0, ack4}, 32'h0);
      check("reset timer_intr4", {31'd0, tint4}, 32'h0);
      rstn = 1'b1;
      @(negedge clk);
      rd_chk(1, A_CMP_HI, 32'hFFFF_FFFF, "reset cmp_hi");
      rd_chk(1, A_CMP_LO, 32'hFFFF_FFFF, "reset cmp_lo");
      rd_chk(1, A_MT_LO, 32'h0, "reset mtime_lo");
      @(negedge clk);
      check("idle rdata zero", rdata1, 32'h0);
      check("idle ack low", {31'd0, ack1}, 32'h0);

      // Table-driven register vectors.
      for (int i = 0; i < 16; i++) begin
         access(4, vecs[i].w, vecs[i].a, vecs[i].d, rd, ak);
         check({vecs[i].name, " ack"}, {31'd0, ak}, 32'd1);
         check(vecs[i].name, rd, vecs[i].exp);
      end

      // Compare at PRESCALE=1.
      wr(1, A_CMP_HI, 32'h0, "cmp_hi=0");
      wr(1, A_CMP_LO, 32'd20, "cmp_lo=20");
      wr(1, A_MT_HI, 32'h0, "mtime_hi=0");
      wr(1, A_MT_LO, 32'h0, "mtime_lo=0");
      wr(1, A_CTRL, 32'h1, "enable");
      check("intr low at enable", {31'd0, tint1}, 32'h0);
      repeat (20) @(negedge clk);
      check("intr low at mtime=20", {31'd0, tint1}, 32'h0);
      @(negedge clk);
      check("intr high 1 cycle later", {31'd0, tint1}, 32'h1);
      wr(1, A_CMP_LO, 32'd1000, "cmp_lo=1000");
      check("intr still high at write", {31'd0, tint1}, 32'h1);
      @(negedge clk);
      check("intr drops next cycle", {31'd0, tint1}, 32'h0);

      // Carry and atomic read at PRESCALE=4.
      wr(4, A_MT_HI, 32'h0, "p4 mtime_hi=0");
      wr(4, A_MT_LO, 32'hFFFF_FFFE, "p4 mtime_lo");
      wr(4, A_CTRL, 32'h1, "p4 enable");
      repeat (7) @(negedge clk);
      rd_chk(4, A_MT_LO, 32'hFFFF_FFFF, "straddle lo");
      rd_chk(4, A_MT_HI, 32'h0, "straddle hi shadow");
      rd_chk(4, A_MT_LO, 32'h0, "after carry lo");
      rd_chk(4, A_MT_HI, 32'h1, "after carry hi");

      // Write colliding with a tick: write wins, tick lost.
      wr(4, A_MT_LO, 32'd5, "collide mtime_lo=5");
      rd_chk(4, A_MT_LO, 32'd5, "collide read lo");
      wr(4, A_CTRL, 32'h0, "p4 disable");
      wr(4, A_MT_LO, 32'd77, "frozen mtime_lo=77");
      repeat (40) @(negedge clk);
      rd_chk(4, A_MT_LO, 32'd77, "frozen lo holds");
      rd_chk(4, A_MT_HI, 32'd1, "frozen hi holds");

      // External interrupt 200-cycle pulse.
      ext_irq_in = 1'b1;
      cnt = 0; first = -1;
      for (int i = 1; i <= 205; i++) begin
         @(negedge clk);
         if (ext1) begin
            cnt++;
            if (first < 0) first = i;
         end
         if (i == 200) ext_irq_in = 1'b0;
      end
      check("ext pulse width", cnt, 32'd200);
      check("ext latency", first, 32'd2);

      // Glitch straddling a rising edge: one output cycle.
      #3 ext_irq_in = 1'b1;
      #4 ext_irq_in = 1'b0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ext1) cnt++;
      end
      check("ext glitch over edge", cnt, 32'd1);

      // Glitch between edges: no output.
      #1 ext_irq_in = 1'b1;
      #2 ext_irq_in = 1'b0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ext1) cnt++;
      end
      check("ext glitch between edges", cnt, 32'd0);

      // Reset in the middle of an access.
      wr(1, A_CMP_LO, 32'h0, "cmp_lo=0");
      @(negedge clk);
      check("intr high before reset", {31'd0, tint1}, 32'h1);
      we = 1'b0; addr = A_MT_LO; req1 = 1'b1;
      #2 rstn = 1'b0;
      #1 check("intr cleared async", {31'd0, tint1}, 32'h0);
      @(negedge clk);
      req1 = 1'b0;
      check("no ack for dropped access", {31'd0, ack1}, 32'h0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("no ack after release", {31'd0, ack1}, 32'h0);
      check("intr low after reset", {31'd0, tint1}, 32'h0);
      rd_chk(1, A_MT_LO, 32'h0, "post-reset mtime_lo");
      rd_chk(1, A_MT_HI, 32'h0, "post-reset mtime_hi");
      rd_chk(1, A_CTRL, 32'h0, "post-reset ctrl");
      rd_chk(4, A_CMP_HI, 32'hFFFF_FFFF, "post-reset p4 cmp_hi");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
